supersonic_sequencer: RTL and testbench
=======================================

Name: supersonic_sequencer

Overview:
- Sequences one HC-SR04-style ultrasonic ranging cycle per request from the main slicing controller.
- Per request: drives the sensor trigger pulse, reports trigger completion, waits for the echo, measures the echo width, converts it to millimetres and returns a single-cycle valid with the distance.
- Sits between the main controller (`trigger`/`triggerSuc`/`valid`/`distance`) and the sensor pins (`trig_out`/`echo`).
- Enforces sensor timing: pulse width, timeouts and re-trigger holdoff.

Parameters:
- TRIG_CYCLES, 500: trig_out high time in clk cycles (10 us at 50 MHz).
- CYC_PER_MM, 291: clk cycles of echo-high per 1 mm of target distance (round trip).
- TIMEOUT_CYCLES, 1900000: max wait for echo rise, and max echo-high time (38 ms).
- HOLDOFF_CYCLES, 3000000: minimum idle time after a measurement before the next trig_out (60 ms).
- MAX_MM, 4000: distance saturation value, also reported on timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- trigger  in  1  measurement request from controller; rising edge detected.
- echo  in  1  asynchronous sensor echo pin.
- trig_out  out  1  sensor trigger pin.
- triggerSuc  out  1  1-cycle pulse: trigger pulse completed.
- valid  out  1  1-cycle pulse: distance/timeout updated.
- distance  out  32  measured distance in mm, held between valids.
- timeout  out  1  qualifies the latest valid: no echo or echo too long; held.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs 0, distance = 0.
  - FSM goes to IDLE; pending flag, counters and synchroniser cleared.
  - Reset in any state aborts the measurement and produces no valid.
- Echo path:
  - 2-flop synchroniser: echo_s is echo delayed 2 clk.
  - Edges are detected on echo_s against its 1-cycle-delayed copy.
- Request:
  - req_edge = trigger & ~trigger_d.
  - In IDLE, req_edge at cycle N moves the FSM to TRIG at N+1.
  - req_edge in any other state sets `pending` (1 deep); further edges while pending are dropped.
- States:
  - IDLE: trig_out = 0.
    - Enter TRIG on req_edge or pending; clear pending on entry.
  - TRIG: trig_out = 1 for exactly TRIG_CYCLES cycles.
    - On the first cycle trig_out is low again: triggerSuc = 1 for 1 cycle; enter WAIT_RISE.
  - WAIT_RISE: counts cycles.
    - On echo_s rising edge: enter MEASURE; clear mm and sub counters.
    - If the count reaches TIMEOUT_CYCLES: enter DONE with distance = MAX_MM, timeout = 1.
  - MEASURE: each cycle echo_s = 1, sub += 1.
    - When sub reaches CYC_PER_MM: sub = 0 and mm += 1, saturating at MAX_MM.
    - On echo_s falling edge: enter DONE with distance = mm, timeout = 0.
    - If echo-high cycles reach TIMEOUT_CYCLES: enter DONE with distance = MAX_MM, timeout = 1.
    - distance = floor(echo_high_cycles / CYC_PER_MM), min MAX_MM.
  - DONE (1 cycle): valid = 1; distance/timeout registers update this same cycle. Enter HOLDOFF.
  - HOLDOFF: exits to IDLE only when HOLDOFF_CYCLES have elapsed AND echo_s = 0.
    - Exit is to IDLE, never directly to TRIG, so a pending request fires 1 cycle later.
- Latency:
  - valid asserts 3 clk after the first sampled-low raw echo: 2 sync + 1 edge/DONE.
- Simultaneous events:
  - req_edge in the DONE cycle is pending, not lost.
  - Echo rise on the same cycle as the WAIT_RISE timeout: timeout wins.
  - Echo fall on the same cycle the MEASURE timeout hits: normal measurement (timeout = 0).
- Counters:
  - 32 bit; no wrap is possible below the timeouts.
  - distance upper bits are 0 for MAX_MM < 2^32.

Test Plan (TRIG_CYCLES=4, CYC_PER_MM=2, TIMEOUT_CYCLES=64, HOLDOFF_CYCLES=8, MAX_MM=20):
- Reset: assert rst 3 cycles while trigger=1, echo=1 -> trig_out, triggerSuc, valid, timeout, busy = 0; distance = 0; no trig_out until a fresh trigger rising edge.
- Normal: trigger pulse -> trig_out high exactly 4 cycles, triggerSuc one pulse; echo high 20 cycles -> exactly one valid 3 cycles after echo falls, distance = 10, timeout = 0; busy falls 8+ cycles later.
- No echo: trigger, echo held 0 -> valid 64 cycles after triggerSuc, distance = 20, timeout = 1.
- Stuck echo: echo high 200 cycles -> valid with distance = 20, timeout = 1 after 64 high cycles; busy stays 1 until echo returns 0 and holdoff expires.
- Queued request: two trigger edges during MEASURE -> only one extra measurement, its trig_out starts 1 cycle after IDLE re-entry; odd echo width 7 cycles -> distance = 3.
- Abort: rst during MEASURE -> trig_out = 0, busy = 0 next cycle, no valid, pending cleared, distance = 0.

Source files
------------

// File: rtl/supersonic_sequencer.sv
// supersonic_sequencer
// Runs one HC-SR04-style ultrasonic ranging cycle per request from the
// controller. It fires the trigger pulse and waits for the echo. It then
// measures the echo width, converts it to millimetres and reports the result
// with a single-cycle valid.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset (aborts any measurement)
//   trigger    measurement request, rising-edge sensitive
//   echo       raw (asynchronous) sensor echo pin
//   trig_out   sensor trigger pin, high for TRIG_CYCLES cycles
//   triggerSuc 1-cycle pulse on the first cycle after trig_out drops
//   valid      1-cycle pulse when distance/timeout have been updated
//   distance   latest distance in mm (MAX_MM on timeout), held
//   timeout    latest result was a timeout (no echo / echo too long), held
//   busy       high whenever the sequencer is not idle
module supersonic_sequencer #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CYC_PER_MM     = 291,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000,
  parameter int unsigned MAX_MM         = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        echo,
  output logic        trig_out,
  output logic        triggerSuc,
  output logic        valid,
  output logic [31:0] distance,
  output logic        timeout,
  output logic        busy
);

  localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_W    = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0] CYC_W        = 32'(CYC_PER_MM);
  localparam logic [31:0] MAX_W        = 32'(MAX_MM);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE,
    HOLDOFF
  } state_t;

  state_t      state_reg, state_next;
  logic        echo_meta_reg, echo_s_reg, echo_d_reg;
  logic        trigger_d_reg;
  logic        pending_reg, pending_next;
  logic        trig_suc_reg, trig_suc_next;
  logic        timeout_reg, timeout_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] sub_reg, sub_next;
  logic [31:0] mm_reg, mm_next;
  logic [31:0] distance_reg, distance_next;

  logic        req_edge, echo_rise, echo_fall;
  logic [31:0] sub_base, mm_base, sub_inc, sub_step, mm_step;

  assign req_edge  = trigger & ~trigger_d_reg;
  assign echo_rise = echo_s_reg & ~echo_d_reg;
  assign echo_fall = ~echo_s_reg & echo_d_reg;

  // One echo-high cycle applied to the mm/sub counters. On the rising-edge
  // cycle the counters start from zero, so that cycle is itself counted as
  // the first high cycle and the result is floor(high_cycles / CYC_PER_MM).
  always_comb begin
    sub_base = (state_reg == MEASURE) ? sub_reg : '0;
    mm_base  = (state_reg == MEASURE) ? mm_reg  : '0;
    sub_inc  = sub_base + 32'd1;
    sub_step = sub_inc;
    mm_step  = mm_base;
    if (sub_inc == CYC_W) begin
      sub_step = '0;
      mm_step  = (mm_base >= MAX_W) ? MAX_W : mm_base + 32'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sub_next      = sub_reg;
    mm_next       = mm_reg;
    distance_next = distance_reg;
    timeout_next  = timeout_reg;
    trig_suc_next = 1'b0;
    pending_next  = pending_reg;

    // A request outside IDLE is remembered once; extra edges are dropped.
    if (req_edge && state_reg != IDLE) pending_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (req_edge || pending_reg) begin
          state_next   = TRIG;
          cnt_next     = '0;
          pending_next = 1'b0;
        end
      end
      TRIG: begin
        if (cnt_reg == TRIG_LAST) begin
          state_next    = WAIT_RISE;
          cnt_next      = '0;
          trig_suc_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      WAIT_RISE: begin
        // Timeout is checked first so it wins over a coincident rise.
        if (cnt_reg == TIMEOUT_LAST) begin
          state_next    = DONE;
          distance_next = MAX_W;
          timeout_next  = 1'b1;
        end else if (echo_rise) begin
          state_next = MEASURE;
          cnt_next   = 32'd1;
          sub_next   = sub_step;
          mm_next    = mm_step;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      MEASURE: begin
        // cnt holds the echo-high cycles seen so far; echo_s is high here
        // unless this is the falling-edge cycle.
        if (echo_fall) begin
          state_next    = DONE;
          distance_next = mm_reg;
          timeout_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
          sub_next = sub_step;
          mm_next  = mm_step;
          if (cnt_reg + 32'd1 == TIMEOUT_W) begin
            state_next    = DONE;
            distance_next = MAX_W;
            timeout_next  = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = HOLDOFF;
        cnt_next   = '0;
      end
      HOLDOFF: begin
        // The counter saturates so a stuck echo simply extends the holdoff.
        if (cnt_reg >= HOLD_LAST && !echo_s_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg < HOLD_LAST) begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // trigger_d follows trigger even during reset: a request held high
  // through reset must not look like a fresh rising edge afterwards.
  always_ff @(posedge clk) begin
    trigger_d_reg <= trigger;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      echo_meta_reg <= 1'b0;
      echo_s_reg    <= 1'b0;
      echo_d_reg    <= 1'b0;
      pending_reg   <= 1'b0;
      trig_suc_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      cnt_reg       <= '0;
      sub_reg       <= '0;
      mm_reg        <= '0;
      distance_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      echo_meta_reg <= echo;
      echo_s_reg    <= echo_meta_reg;
      echo_d_reg    <= echo_s_reg;
      pending_reg   <= pending_next;
      trig_suc_reg  <= trig_suc_next;
      timeout_reg   <= timeout_next;
      cnt_reg       <= cnt_next;
      sub_reg       <= sub_next;
      mm_reg        <= mm_next;
      distance_reg  <= distance_next;
    end
  end

  assign trig_out   = (state_reg == TRIG);
  assign valid      = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign triggerSuc = trig_suc_reg;
  assign timeout    = timeout_reg;
  assign distance   = distance_reg;

endmodule

// File: tb/tb_supersonic_sequencer.sv
module tb_supersonic_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        echo;
  logic        trig_out;
  logic        triggerSuc;
  logic        valid;
  logic [31:0] distance;
  logic        timeout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  supersonic_sequencer #(
    .TRIG_CYCLES   (4),
    .CYC_PER_MM    (2),
    .TIMEOUT_CYCLES(64),
    .HOLDOFF_CYCLES(8),
    .MAX_MM        (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .echo      (echo),
    .trig_out  (trig_out),
    .triggerSuc(triggerSuc),
    .valid     (valid),
    .distance  (distance),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are read and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // From IDLE: request, expect trig_out high for exactly 4 cycles, then a
  // triggerSuc pulse with trig_out low. Returns on the triggerSuc cycle.
  task automatic do_trigger(input string tag);
    int hi = 0;
    int suc = 0;
    trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      trigger = 1'b0;
      hi  += int'(trig_out);
      suc += int'(triggerSuc);
    end
    check({tag, "_trig_len"}, 32'(hi), 32'd4);
    check({tag, "_suc_early"}, 32'(suc), 32'd0);
    tick();
    check({tag, "_trig_low"}, {31'd0, trig_out}, 32'd0);
    check({tag, "_suc"}, {31'd0, triggerSuc}, 32'd1);
  endtask

  // Hold echo high for n cycles, drop it, expect valid exactly 3 cycles later.
  task automatic echo_pulse(input string tag, input int n, input logic [31:0] exp_mm);
    int v = 0;
    echo = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      v += int'(valid);
    end
    echo = 1'b0;
    tick(); v += int'(valid);
    tick(); v += int'(valid);
    check({tag, "_early_valid"}, 32'(v), 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_dist"}, distance, exp_mm);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  // From the valid cycle: busy holds 8 holdoff cycles, then falls.
  task automatic holdoff_exit(input string tag);
    int b = 0;
    int v = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      b += int'(busy);
      v += int'(valid);
    end
    check({tag, "_hold_busy"}, 32'(b), 32'd8);
    check({tag, "_single_valid"}, 32'(v), 32'd0);
    tick();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    int cnt2;

    // Reset with trigger and echo high.
    rst = 1'b1; trigger = 1'b1; echo = 1'b1;
    tick();
    check("rst_trig_out", {31'd0, trig_out}, 32'd0);
    check("rst_suc", {31'd0, triggerSuc}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dist", distance, 32'd0);
    tick(); tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(trig_out) + int'(busy);
    end
    check("post_rst_no_fire", 32'(cnt), 32'd0);
    trigger = 1'b0; echo = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Normal: 20 echo-high cycles -> 10 mm.
    do_trigger("norm");
    tick();
    check("norm_suc_1cyc", {31'd0, triggerSuc}, 32'd0);
    echo_pulse("norm", 20, 32'd10);
    check("norm_busy", {31'd0, busy}, 32'd1);
    holdoff_exit("norm");

    // No echo: valid 64 cycles after triggerSuc, saturated + timeout.
    do_trigger("noecho");
    cnt = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      cnt += int'(valid);
    end
    check("noecho_early_valid", 32'(cnt), 32'd0);
    tick();
    check("noecho_valid", {31'd0, valid}, 32'd1);
    check("noecho_dist", distance, 32'd20);
    check("noecho_timeout", {31'd1 & 31'd0, timeout}, 32'd1);
    holdoff_exit("noecho");

    // Stuck echo: 200 high cycles, timeout after 64 high cycles.
    do_trigger("stuck");
    echo = 1'b1;
    cnt = 0;
    for (int i = 0; i < 65; i++) begin
      tick();
      cnt += int'(valid);
    end
    check("stuck_early_valid", 32'(cnt), 32'd0);
    tick();
    check("stuck_valid", {31'd0, valid}, 32'd1);
    check("stuck_dist", distance, 32'd20);
    check("stuck_timeout", {31'd0, timeout}, 32'd1);
    cnt = 0; cnt2 = 0;
    for (int i = 66; i < 200; i++) begin
      tick();
      cnt  += int'(!busy);
      cnt2 += int'(valid);
    end
    check("stuck_busy_held", 32'(cnt), 32'd0);
    check("stuck_one_valid", 32'(cnt2), 32'd0);
    echo = 1'b0;
    tick(); tick();
    check("stuck_busy_until_low", {31'd0, busy}, 32'd1);
    tick();
    check("stuck_idle", {31'd0, busy}, 32'd0);
    check("stuck_timeout_held", {31'd0, timeout}, 32'd1);
    tick();

    // Queued: two trigger edges during MEASURE, echo 7 cycles -> 3 mm.
    do_trigger("queue");
    echo = 1'b1;
    tick(); tick(); tick();
    trigger = 1'b1; tick();
    trigger = 1'b0; tick();
    trigger = 1'b1; tick();
    trigger = 1'b0; tick();
    echo = 1'b0;
    tick(); tick();
    check("queue_no_valid_yet", {31'd0, valid}, 32'd0);
    tick();
    check("queue_valid", {31'd0, valid}, 32'd1);
    check("queue_dist", distance, 32'd3);
    check("queue_timeout", {31'd0, timeout}, 32'd0);
    holdoff_exit("queue");
    check("queue_idle_trig_low", {31'd0, trig_out}, 32'd0);
    tick();
    check("queue_refire", {31'd0, trig_out}, 32'd1);
    tick(); tick(); tick();
    check("queue_refire_len", {31'd0, trig_out}, 32'd1);
    tick();
    check("queue_refire_suc", {31'd0, triggerSuc}, 32'd1);
    echo_pulse("queue2", 4, 32'd2);
    holdoff_exit("queue2");
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt += int'(trig_out);
    end
    check("queue_only_one_extra", 32'(cnt), 32'd0);

    // Abort: reset during MEASURE with a pending request.
    do_trigger("abort");
    echo = 1'b1;
    tick(); tick(); tick();
    trigger = 1'b1; tick();
    trigger = 1'b0;
    rst = 1'b1;
    tick();
    check("abort_trig_out", {31'd0, trig_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dist", distance, 32'd0);
    check("abort_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0; echo = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(valid) + int'(trig_out) + int'(busy);
    end
    check("abort_quiet", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
